// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
//   program counter, issues word reads on a 16-bit instruction-memory
//   handshake, and produces the branched / stall / continue controls that
//   the IF/ID register uses for flushes and bubbles.
//
//   Optional feature macro: IF_PERF_CNT_EN
//     defined   -> adds saturating fetch_cnt / stall_cnt performance counters
//     undefined -> no counter ports and no counter logic
//
//   The stall countdown port is called continue_o because "continue" is a
//   reserved word in SystemVerilog.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int unsigned           ADDR_W       = 16,
   parameter logic [ADDR_W-1:0]     RESET_PC     = '0,
   parameter int unsigned           STALL_CYCLES = 3,
   parameter logic [15:0]           HALT_OPCODE  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              stall_req,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       instruction,
   output logic [ADDR_W-1:0] next_address,
   output logic              if_valid,
   output logic              branched,
   output logic              stall,
   output logic [2:0]        continue_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]       fetch_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   // Countdown value loaded when a stall window opens or is re-armed.
   localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] pc_q,       pc_d;
   logic [15:0]       instr_q,    instr_d;
   logic [ADDR_W-1:0] naddr_q,    naddr_d;
   logic              if_valid_q, if_valid_d;
   logic              branched_q, branched_d;
   logic              stall_q,    stall_d;
   logic [2:0]        cont_q,     cont_d;

   // Fall-through address; wraps modulo 2^ADDR_W.
   logic [ADDR_W-1:0] pc_inc;
   assign pc_inc = pc_q + ADDR_W'(1);

   // Memory handshake: address always tracks the PC, requests only in FETCH
   // and never while reset is asserted.
   assign imem_addr = pc_q;
   assign imem_req  = (state_q == ST_FETCH) && rst_n;

   assign instruction  = instr_q;
   assign next_address = naddr_q;
   assign if_valid     = if_valid_q;
   assign branched     = branched_q;
   assign stall        = stall_q;
   assign continue_o   = cont_q;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= 16'h0000;
         naddr_q    <= RESET_PC;
         if_valid_q <= 1'b0;
         branched_q <= 1'b0;
         stall_q    <= 1'b0;
         cont_q     <= 3'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         naddr_q    <= naddr_d;
         if_valid_q <= if_valid_d;
         branched_q <= branched_d;
         stall_q    <= stall_d;
         cont_q     <= cont_d;
      end
   end

   // Next-state logic: branch beats stall beats memory response.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      naddr_d    = naddr_q;
      if_valid_d = 1'b0;
      branched_d = 1'b0;
      stall_d    = stall_q;
      cont_d     = cont_q;

      if (branch_taken) begin
         // Redirect from any state; any same-cycle response is dropped and the
         // IF/ID register gets a one-cycle flush.
         state_d    = ST_FETCH;
         pc_d       = branch_target;
         branched_d = 1'b1;
         stall_d    = 1'b0;
         cont_d     = 3'd0;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (stall_req) begin
                  // Open a stall window; the in-flight word is refetched later.
                  state_d = ST_STALL;
                  stall_d = 1'b1;
                  cont_d  = STALL_LOAD;
               end else if (imem_ready) begin
                  instr_d    = imem_rdata;
                  naddr_d    = pc_inc;
                  if_valid_d = 1'b1;
                  if (imem_rdata == HALT_OPCODE) begin
                     // Halt word is still presented, but the PC parks on it.
                     state_d = ST_HALT;
                  end else begin
                     pc_d = pc_inc;
                  end
               end
            end

            ST_STALL: begin
               if (stall_req) begin
                  cont_d = STALL_LOAD;
               end else if (cont_q == 3'd1) begin
                  cont_d  = 3'd0;
                  stall_d = 1'b0;
                  state_d = ST_FETCH;
               end else begin
                  cont_d = cont_q - 3'd1;
               end
            end

            ST_HALT: begin
               // Parked until a branch or reset; stall requests are ignored.
            end

            default: begin
               state_d = ST_FETCH;
               stall_d = 1'b0;
               cont_d  = 3'd0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Saturating counters: one per presented word, one per stalled cycle.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (if_valid_q && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if (stall_q && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives a 16-bit instruction-memory handshake. Each accepted word is presented together with its fall-through address. Its branched/stall/continue outputs feed the IF/ID register's flush and bubble controls. Registers update on posedge clk; the IF/ID register samples on negedge, giving a half-cycle of settling.

Parameters:
ADDR_W, 16, PC / memory address width
RESET_PC, 16'h0000, PC value after reset
STALL_CYCLES, 3, length of a stall window, loaded into continue (1..7)
HALT_OPCODE, 16'hFFFF, instruction word that halts fetch

Ports:
clk  in  1  clock, posedge
rst_n  in  1  synchronous active-low reset
branch_taken  in  1  redirect request from execute
branch_target  in  ADDR_W  redirect PC
stall_req  in  1  hazard stall request from decode
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  memory word address (= pc)
imem_ready  in  1  imem_rdata valid this cycle
imem_rdata  in  16  fetched word
instruction  out  16  last accepted word, to IF/ID
next_address  out  ADDR_W  address of accepted word + 1
if_valid  out  1  one-cycle pulse per accepted word
branched  out  1  one-cycle flush pulse, to IF/ID
stall  out  1  high while in STALL, to IF/ID
continue  out  3  stall countdown, to IF/ID

Behaviour:
- Reset: the interface is fixed as one clock (clk) and a synchronous, active-low reset (rst_n). Sampled low at posedge: state=FETCH, pc=RESET_PC, instruction=16'h0000, next_address=RESET_PC, if_valid=0, branched=0, stall=0, continue=0. imem_req is held 0 while rst_n=0. Reset mid-transaction discards any in-flight response.
- imem_addr = pc at all times. imem_req = (state==FETCH) && rst_n.
- Word addressing: pc increments by 1, modulo 2^ADDR_W. FFFF wraps to 0000 silently.
- States: FETCH, STALL, HALT. Per-posedge priority: reset > branch_taken > stall_req > imem_ready.
- branch_taken, any state:
  - pc <= branch_target; state <= FETCH; branched <= 1 for exactly one cycle.
  - stall <= 0, continue <= 0, if_valid <= 0; instruction and next_address hold.
  - A same-cycle imem_ready is discarded.
- FETCH, stall_req=1 (no branch):
  - state <= STALL; stall <= 1; continue <= STALL_CYCLES; pc holds.
  - A same-cycle imem_ready word is discarded and refetched after the stall.
- FETCH, imem_ready=1 (no branch, no stall):
  - instruction <= imem_rdata; next_address <= pc+1; pc <= pc+1; if_valid <= 1.
  - If imem_rdata==HALT_OPCODE: state <= HALT and pc holds (not incremented). The halt word is still presented with if_valid=1.
- FETCH, imem_ready=0: hold everything; if_valid <= 0. There is no timeout.
- STALL: continue decrements by 1 each cycle.
  - When continue==1 at a posedge: continue <= 0, stall <= 0, state <= FETCH.
  - stall_req while in STALL re-arms continue to STALL_CYCLES. imem_ready is ignored.
- HALT: imem_req=0; pc holds. Only branch_taken or reset exits. stall_req is ignored.
- if_valid and branched are never high in the same cycle.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0].
  - fetch_cnt increments on every if_valid pulse.
  - stall_cnt increments on every cycle with stall=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
1. Reset, then imem_ready=1 every cycle with rdata=16'h1000+addr -> imem_addr 0,1,2,3; instruction 1000,1001,1002; next_address 1,2,3; if_valid continuously high from the first accepted cycle.
2. imem_ready=0 for 3 cycles at pc=5 -> imem_req stays 1, pc holds 5, if_valid=0 for those cycles, instruction unchanged; first ready cycle accepts the word at addr 5.
3. stall_req for 1 cycle at pc=4 with imem_ready=1 -> word discarded; stall=1 for 3 cycles, continue 3,2,1 then 0; imem_req=0 during the stall; the next accepted word is from addr 4.
4. branch_taken with target 16'h0040, same cycle as imem_ready and stall_req -> branched=1 for one cycle, no if_valid, no stall; next imem_addr=0040.
5. rdata=16'hFFFF accepted at addr 9 -> if_valid pulses with instruction FFFF, then HALT: imem_req=0, pc=9 for 10+ cycles; branch_taken to 0x20 resumes fetch at 0020.
6. pc=16'hFFFF with ready=1 -> next_address=0000, next imem_addr=0000. rst_n low mid-STALL (continue=2) -> next cycle stall=0, continue=0, pc=RESET_PC.
